// File: rtl/trig_event_capture.sv
// trig_event_capture: armed rising-edge capture of N_EVT level events,
// with sticky flags, a saturating capture counter and re-trigger holdoff.
//
// Optional feature: define TRIG_EVT_TIMESTAMP_EN to add a 32-bit
// free-running timestamp, latched into last_ts on each capture cycle.
// Without it, last_ts is tied to 0.
//
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset
//   evt_in             : level event sources (rising edges are captured)
//   arm, disarm        : control pulses (disarm has priority)
//   ack                : per-bit clear of sticky flags
//   clear_cnt          : zero evt_count and ovf
//   trig_out           : one-cycle pulse per captured edge
//   sticky, pending    : latched captures and their OR
//   evt_count, ovf     : saturating count of capture cycles, overflow flag
//   state              : 00 IDLE, 01 ARMED, 10 HOLD
//   last_ts            : timestamp of the last capture
module trig_event_capture #(
    parameter int N_EVT   = 8,
    parameter int CNT_W   = 16,
    parameter int HOLDOFF = 1024
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [N_EVT-1:0] evt_in,
    input  logic             arm,
    input  logic             disarm,
    input  logic [N_EVT-1:0] ack,
    input  logic             clear_cnt,
    output logic [N_EVT-1:0] trig_out,
    output logic [N_EVT-1:0] sticky,
    output logic             pending,
    output logic [CNT_W-1:0] evt_count,
    output logic             ovf,
    output logic [1:0]       state,
    output logic [31:0]      last_ts
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_HOLD  = 2'b10
    } st_t;

    // Loaded with HOLDOFF-1 so HOLD lasts exactly HOLDOFF cycles.
    localparam logic [23:0]      HOLD_LOAD = 24'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    st_t              st_q;
    st_t              st_d;
    logic [N_EVT-1:0] evt_q;
    logic [N_EVT-1:0] cap_vec;
    logic             cap;
    logic [23:0]      hold_q;

    // evt_q resets to 0, but state is IDLE for at least one clock after
    // reset, so a level already high at release is never seen as an edge.
    assign cap_vec = evt_in & ~evt_q & {N_EVT{st_q == S_ARMED}};
    assign cap     = |cap_vec;
    assign pending = |sticky;
    assign state   = st_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st_q <= S_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            S_IDLE:  if (arm) st_d = S_ARMED;
            S_ARMED: if (cap) st_d = S_HOLD;
            S_HOLD:  if (hold_q == '0) st_d = S_ARMED;
            default: st_d = S_IDLE;
        endcase
        if (disarm) st_d = S_IDLE;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold_q <= '0;
        end else if (st_q == S_ARMED && st_d == S_HOLD) begin
            hold_q <= HOLD_LOAD;
        end else if (st_q == S_HOLD && hold_q != '0) begin
            hold_q <= hold_q - 24'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            evt_q    <= '0;
            trig_out <= '0;
            sticky   <= '0;
        end else begin
            evt_q    <= evt_in;
            trig_out <= cap_vec;
            // A new capture wins over a coincident ack on the same bit.
            sticky   <= (sticky & ~ack) | cap_vec;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            evt_count <= '0;
            ovf       <= 1'b0;
        end else if (cap) begin
            if (clear_cnt) begin
                evt_count <= CNT_W'(1);
                ovf       <= 1'b0;
            end else if (evt_count == CNT_MAX) begin
                ovf       <= 1'b1;
            end else begin
                evt_count <= evt_count + CNT_W'(1);
            end
        end else if (clear_cnt) begin
            evt_count <= '0;
            ovf       <= 1'b0;
        end
    end

`ifdef TRIG_EVT_TIMESTAMP_EN
    logic [31:0] ts_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ts_q    <= '0;
            last_ts <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (cap) last_ts <= ts_q;
        end
    end
`else
    assign last_ts = '0;
`endif

endmodule
